// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory controller: lane steering, load extension, pipeline stall,
// misalignment and bus-timeout flags. Define DMEM_POSTED_WRITE_EN for a posted store buffer.
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_mem_r,
  input  logic        cpu_mem_w,
  input  logic [1:0]  cpu_byte,
  input  logic        cpu_unsi,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access, misaligned, start, expire, finish;
  logic             is_byte, is_half;
  logic             post_store, posted;
  logic [1:0]       size_q, off_q;
  logic             unsi_q;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] k);
    case (sz)
      2'b10:   return 4'b0001 << k;
      2'b01:   return k[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b10:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] k, input logic unsi);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {k, 3'b000});
    h = k[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b10:   return unsi ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return unsi ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign is_byte    = (cpu_byte == 2'b10);
  assign is_half    = (cpu_byte == 2'b01);
  assign access     = cpu_mem_r | cpu_mem_w;
  assign misaligned = is_half ? cpu_addr[0] : (!is_byte && (cpu_addr[1:0] != 2'b00));
  assign start      = (state == IDLE) && access && !misaligned;
  assign expire     = (cnt == CNT_W'(TIMEOUT - 1));
  assign finish     = bus_ack || expire;

`ifdef DMEM_POSTED_WRITE_EN
  // Stores are captured and drained in the background without holding the pipeline.
  assign post_store = cpu_mem_w;
`else
  assign post_store = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A drained posted store skips DONE so a waiting request is seen in IDLE at once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = REQ;
      REQ:     if (finish) state_nxt = posted ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      IDLE:    cpu_stall = start && !post_store;
      REQ:     cpu_stall = posted ? access : 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      posted    <= 1'b0;
    end else begin
      align_err <= (state == IDLE) && access && misaligned;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= cpu_mem_w;
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_be    <= lane_be(cpu_byte, cpu_addr[1:0]);
            bus_wdata <= lane_wdata(cpu_byte, cpu_wdata);
            cnt       <= '0;
            posted    <= post_store;
          end else if (access && misaligned) begin
            cpu_rdata <= '0;
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_ack) begin
            bus_req <= 1'b0;
            posted  <= 1'b0;
            if (!bus_we) cpu_rdata <= extend(bus_rdata, size_q, off_q, unsi_q);
          end else if (expire) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            posted  <= 1'b0;
            if (!bus_we) cpu_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Load formatting controls captured with the request; pure data, no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      size_q <= cpu_byte;
      off_q  <= cpu_addr[1:0];
      unsi_q <= cpu_unsi;
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized bench for dmem_bus_ctrl (default build) against a transaction-level model.
module tb_dmem_bus_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        cpu_mem_r, cpu_mem_w, cpu_unsi, cpu_stall, align_err, bus_err;
  logic        bus_req, bus_we, bus_ack;
  logic [1:0]  cpu_byte;
  logic [3:0]  bus_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata = '0;

  dmem_bus_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mem_r(cpu_mem_r), .cpu_mem_w(cpu_mem_w),
    .cpu_byte(cpu_byte), .cpu_unsi(cpu_unsi), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .align_err(align_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_mem_r = 1'b0;
    cpu_mem_w = 1'b0;
    bus_ack   = 1'b0;
  endtask

  // One CPU access; delay = REQ cycle carrying bus_ack (1..TIMEOUT), anything else never acks.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input bit r, input bit w,
                        input logic [1:0] sz, input bit u, input int delay, input logic [31:0] rd);
    int          k, j, stalls, shift;
    bit          mis, acked, done;
    logic [31:0] ebe, ewd, lane;
    k = int'(a[1:0]);
    if (sz == 2'b01)      mis = (k % 2) != 0;
    else if (sz == 2'b10) mis = 1'b0;
    else                  mis = (k != 0);
    if (sz == 2'b10)      begin ebe = 32'(1) << k;            ewd = {24'd0, wd[7:0]} * 32'h0101_0101;  end
    else if (sz == 2'b01) begin ebe = 32'(3) << (k / 2 * 2);  ewd = {16'd0, wd[15:0]} * 32'h0001_0001; end
    else                  begin ebe = 32'hF;                  ewd = wd;                                end
    acked = (delay >= 1) && (delay <= TIMEOUT);

    cpu_addr = a; cpu_wdata = wd; cpu_mem_r = r; cpu_mem_w = w; cpu_byte = sz; cpu_unsi = u;
    #1;
    chk("stall_first", 32'(cpu_stall), 32'(!mis));
    if (mis) begin
      @(negedge clk);
      exp_rdata = '0;
      chk("align_err_pulse", 32'(align_err), 32'd1);
      chk("align_no_req", 32'(bus_req), 32'd0);
      chk("align_no_stall", 32'(cpu_stall), 32'd0);
      chk("align_rdata", cpu_rdata, exp_rdata);
      idle_inputs();
      @(negedge clk);
      chk("align_err_clear", 32'(align_err), 32'd0);
      return;
    end

    stalls = 1; j = 0; done = 1'b0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
      if (cpu_stall) begin
        stalls++;
        if (j == 1) begin
          chk("req_up", 32'(bus_req), 32'd1);
          chk("req_we", 32'(bus_we), 32'(w));
          chk("req_addr", bus_addr, {a[31:2], 2'b00});
          chk("req_be", 32'(bus_be), ebe);
          chk("req_wdata", bus_wdata, ewd);
        end
        bus_ack   = (j == delay);
        bus_rdata = (j == delay) ? rd : $urandom;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("stall_bound", 32'(j), 32'd0);
      idle_inputs();
      return;
    end

    if (!w) begin
      if (!acked) exp_rdata = '0;
      else begin
        shift = (sz == 2'b10) ? 8 * k : (sz == 2'b01) ? 8 * (k / 2 * 2) : 0;
        lane  = rd >> shift;
        if (sz == 2'b10) begin
          lane = lane & 32'hFF;
          if (!u && lane[7]) lane = lane | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
          lane = lane & 32'hFFFF;
          if (!u && lane[15]) lane = lane | 32'hFFFF_0000;
        end
        exp_rdata = lane;
      end
    end
    chk("stall_cycles", 32'(stalls), acked ? 32'(delay + 1) : 32'(TIMEOUT + 1));
    chk("done_req_low", 32'(bus_req), 32'd0);
    chk("done_bus_err", 32'(bus_err), 32'(!acked));
    chk("done_rdata", cpu_rdata, exp_rdata);
    idle_inputs();
    @(negedge clk);
    chk("after_bus_err", 32'(bus_err), 32'd0);
    chk("after_stall", 32'(cpu_stall), 32'd0);
    chk("after_rdata", cpu_rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_byte = '0; cpu_unsi = 1'b0; bus_rdata = '0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_errs", {30'd0, align_err, bus_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(32'h100, 32'h0, 1, 0, 2'b00, 0, 3, 32'hDEAD_BEEF);
    access(32'h103, 32'h0, 1, 0, 2'b10, 0, 1, 32'h80FF_FF7F);
    access(32'h103, 32'h0, 1, 0, 2'b10, 1, 2, 32'h80FF_FF7F);
    access(32'h202, 32'h1234_ABCD, 0, 1, 2'b01, 0, 2, 32'h0);
    access(32'h101, 32'h0, 1, 0, 2'b00, 0, 1, 32'h0);
    access(32'h400, 32'h0, 1, 0, 2'b00, 0, TIMEOUT, 32'h1357_9BDF);
    access(32'h404, 32'h0, 1, 0, 2'b00, 0, 0, 32'hFFFF_FFFF);
    access(32'h500, 32'hCAFE_F00D, 1, 1, 2'b11, 0, 4, 32'h0);

    // Reset in the middle of a request, followed by a stale acknowledge.
    cpu_addr = 32'h300; cpu_byte = 2'b00; cpu_mem_r = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_req_up", 32'(bus_req), 32'd1);
    #2;
    cpu_mem_r = 1'b0;
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    chk("mid_rst_req", 32'(bus_req), 32'd0);
    chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_req", 32'(bus_req), 32'd0);
    chk("late_ack_rdata", cpu_rdata, exp_rdata);
    chk("late_ack_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rw, rb;
      bit          rr, ww;
      int          d;
      ra = $urandom; rw = $urandom; rb = $urandom;
      ww = ($urandom_range(0, 2) == 0);
      rr = !ww || ($urandom_range(0, 3) == 0);
      d  = $urandom_range(0, 17);
      access(ra, rw, rr, ww, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
